// File: rtl/sprite_pixel_pipe.sv
// sprite_pixel_pipe: two-stage sprite compositor with shadow/active sprite registers committed at (0,480).
// Define SPRITE_COLLISION_EN to add sticky per-sprite collision flags reported at each commit.
module sprite_pixel_pipe #(
  parameter int          NUM_SPR  = 4,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic               VGA_clk,
  input  logic               rst,
  input  logic [9:0]         xCount,
  input  logic [9:0]         yCount,
  input  logic               blank_n,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               wr_en,
  input  logic [2:0]         wr_idx,
  input  logic [9:0]         wr_x,
  input  logic [9:0]         wr_y,
  input  logic [6:0]         wr_w,
  input  logic [6:0]         wr_h,
  input  logic [23:0]        wr_color,
  input  logic               wr_vis,
  output logic [7:0]         r_out,
  output logic [7:0]         g_out,
  output logic [7:0]         b_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               blank_n_out,
  output logic               frame_tick,
  output logic [NUM_SPR-1:0] coll_flags
);
  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [6:0]  w;
    logic [6:0]  h;
    logic [23:0] color;
    logic        vis;
  } spr_t;
  spr_t [NUM_SPR-1:0] shd_q, shd_d, act_q, act_d;
  logic [9:0]  x1_q, x1_d, y1_q, y1_d;
  logic        bl1_q, bl1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [23:0] rgb_q, rgb_d, col;
  logic        bl2_q, bl2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [NUM_SPR-1:0] hit;
  logic        commit;
  always_comb begin
    commit = xCount == 10'd0 && yCount == 10'd480;
    shd_d  = shd_q;
    for (int i = 0; i < NUM_SPR; i++)
      if (wr_en && wr_idx == 3'(i)) shd_d[i] = {wr_x, wr_y, wr_w, wr_h, wr_color, wr_vis};
    act_d = commit ? shd_q : act_q;
    {x1_d, y1_d, bl1_d, hs1_d, vs1_d} = {xCount, yCount, blank_n, hsync, vsync};
    // 11-bit bounds so sprites running off the right/bottom edge clip instead of wrapping
    for (int i = 0; i < NUM_SPR; i++)
      hit[i] = act_q[i].vis
            && {1'b0, x1_q} >= {1'b0, act_q[i].x} && {1'b0, x1_q} < {1'b0, act_q[i].x} + {4'b0, act_q[i].w}
            && {1'b0, y1_q} >= {1'b0, act_q[i].y} && {1'b0, y1_q} < {1'b0, act_q[i].y} + {4'b0, act_q[i].h};
    col = BG_COLOR;
    for (int i = NUM_SPR - 1; i >= 0; i--)
      if (hit[i]) col = act_q[i].color;
    rgb_d = bl1_q ? col : 24'h0;
    {bl2_d, hs2_d, vs2_d} = {bl1_q, hs1_q, vs1_q};
  end
  always_ff @(posedge VGA_clk or posedge rst)
    if (rst) begin
      shd_q <= '0;
      act_q <= '0;
      {x1_q, y1_q} <= '0;
      {bl1_q, hs1_q, vs1_q} <= 3'b011;
      rgb_q <= '0;
      {bl2_q, hs2_q, vs2_q} <= 3'b011;
    end else begin
      shd_q <= shd_d;
      act_q <= act_d;
      {x1_q, y1_q} <= {x1_d, y1_d};
      {bl1_q, hs1_q, vs1_q} <= {bl1_d, hs1_d, vs1_d};
      rgb_q <= rgb_d;
      {bl2_q, hs2_q, vs2_q} <= {bl2_d, hs2_d, vs2_d};
    end
  assign {r_out, g_out, b_out} = rgb_q;
  assign {blank_n_out, hsync_out, vsync_out} = {bl2_q, hs2_q, vs2_q};
  assign frame_tick = commit & ~rst;
`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPR-1:0] stk_q, stk_d, coll_q, coll_d;
  logic               multi;
  always_comb begin
    multi  = bl1_q && (hit & (hit - NUM_SPR'(1))) != '0;
    stk_d  = commit ? '0 : stk_q | (multi ? hit : '0);
    coll_d = commit ? stk_q : coll_q;
  end
  always_ff @(posedge VGA_clk or posedge rst)
    if (rst) begin
      stk_q  <= '0;
      coll_q <= '0;
    end else begin
      stk_q  <= stk_d;
      coll_q <= coll_d;
    end
  assign coll_flags = coll_q;
`else
  assign coll_flags = '0;
`endif
endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// tb_sprite_pixel_pipe: table-driven pixel vectors checked through a 2-deep scoreboard queue.
module tb_sprite_pixel_pipe;
  localparam logic [23:0] BG = 24'h102030;
  typedef struct {
    int          ph;
    logic [9:0]  x, y;
    logic        bl, hs, vs;
    logic [23:0] rgb;
  } vec_t;
  typedef struct {
    logic [23:0] rgb;
    logic        hs, vs, bl, chk;
    int          tag;
  } exp_t;
  logic clk = 0, rst = 1;
  logic [9:0] x = 0, y = 480;
  logic bl = 0, hs = 1, vs = 1;
  logic wr_en = 0, wr_vis = 0;
  logic [2:0] wr_idx = 0;
  logic [9:0] wr_x = 0, wr_y = 0;
  logic [6:0] wr_w = 0, wr_h = 0;
  logic [23:0] wr_color = 0;
  logic [7:0] r, g, b;
  logic hs_o, vs_o, bl_o, ft;
  logic [3:0] coll;
  vec_t tbl[$];
  exp_t q[$];
  int checks = 0, failures = 0, tag = 0;

  sprite_pixel_pipe #(.NUM_SPR(4), .BG_COLOR(BG)) dut (
    .VGA_clk(clk), .rst(rst), .xCount(x), .yCount(y), .blank_n(bl), .hsync(hs), .vsync(vs),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_w(wr_w), .wr_h(wr_h),
    .wr_color(wr_color), .wr_vis(wr_vis), .r_out(r), .g_out(g), .b_out(b),
    .hsync_out(hs_o), .vsync_out(vs_o), .blank_n_out(bl_o), .frame_tick(ft), .coll_flags(coll));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && q.size() >= 2) begin
      e = q.pop_front();
      if (e.chk) begin
        checks++;
        if ({r, g, b, hs_o, vs_o, bl_o} !== {e.rgb, e.hs, e.vs, e.bl}) begin
          failures++;
          $display("FAIL pix%0d got rgb=%h hs=%b vs=%b bl=%b exp rgb=%h hs=%b vs=%b bl=%b",
                   e.tag, {r, g, b}, hs_o, vs_o, bl_o, e.rgb, e.hs, e.vs, e.bl);
        end
      end
    end
  end

  task automatic step(input logic [9:0] px, input logic [9:0] py, input logic pbl, input logic phs,
                      input logic pvs, input logic [23:0] prgb, input logic pchk);
    exp_t e;
    {x, y, bl, hs, vs} = {px, py, pbl, phs, pvs};
    e.rgb = prgb; e.hs = phs; e.vs = pvs; e.bl = pbl; e.chk = pchk; e.tag = tag++;
    q.push_back(e);
    #1;
    if (px == 0 && py == 480) chk("frame_tick", 32'(ft), 1);
    @(negedge clk);
  endtask

  task automatic idle();
    step(700, 500, 0, 1, 1, 0, 0);
  endtask

  task automatic commit();
    step(0, 480, 0, 1, 0, 0, 1);
  endtask

  task automatic wr(input logic [2:0] i, input logic [9:0] sx, input logic [9:0] sy, input logic [6:0] sw,
                    input logic [6:0] sh, input logic [23:0] c, input logic v, input logic at_commit);
    {wr_idx, wr_x, wr_y, wr_w, wr_h, wr_color, wr_vis} = {i, sx, sy, sw, sh, c, v};
    wr_en = 1;
    if (at_commit) commit(); else idle();
    wr_en = 0;
  endtask

  task automatic add(input int ph, input logic [9:0] px, input logic [9:0] py, input logic pbl,
                     input logic phs, input logic pvs, input logic [23:0] prgb);
    vec_t v;
    v.ph = ph; v.x = px; v.y = py; v.bl = pbl; v.hs = phs; v.vs = pvs; v.rgb = prgb;
    tbl.push_back(v);
  endtask

  task automatic apply(input int ph);
    foreach (tbl[k])
      if (tbl[k].ph == ph) step(tbl[k].x, tbl[k].y, tbl[k].bl, tbl[k].hs, tbl[k].vs, tbl[k].rgb, 1);
    idle();
    idle();
  endtask

  initial begin
    add(1, 100, 50, 1, 1, 1, 24'hFF0000); add(1, 109, 59, 1, 1, 1, 24'hFF0000);
    add(1, 110, 50, 1, 1, 1, BG);         add(1, 99, 50, 1, 1, 1, BG);
    add(1, 100, 60, 1, 1, 1, BG);         add(1, 100, 49, 1, 1, 1, BG);
    add(2, 200, 200, 1, 1, 1, 24'h0000FF); add(2, 212, 212, 1, 1, 1, 24'h00FF00);
    add(2, 100, 50, 1, 1, 1, BG);
    add(3, 200, 200, 1, 1, 1, 24'h00FF00);
    add(4, 300, 300, 1, 1, 1, BG);
    add(5, 300, 300, 1, 1, 1, 24'hABCDEF);
    add(6, 300, 300, 1, 1, 1, 24'hABCDEF);
    add(7, 635, 100, 1, 1, 1, 24'h00AA00); add(7, 639, 100, 1, 1, 1, 24'h00AA00);
    add(7, 0, 100, 1, 1, 1, BG);           add(7, 14, 100, 1, 1, 1, BG);
    add(7, 650, 100, 0, 0, 1, 24'h0);      add(7, 660, 100, 0, 0, 0, 24'h0);
    add(7, 700, 101, 0, 1, 0, 24'h0);      add(7, 634, 100, 1, 1, 1, BG);
    add(8, 320, 240, 1, 1, 1, BG);         add(8, 200, 200, 1, 1, 1, BG);
    add(8, 100, 50, 1, 1, 1, BG);

    repeat (2) @(negedge clk);
    chk("rst_rgb", 32'({r, g, b}), 0);
    chk("rst_sync", 32'({hs_o, vs_o, bl_o}), 32'b110);
    chk("rst_tick", 32'(ft), 0);
    chk("rst_coll", 32'(coll), 0);
    rst = 0;
    step(320, 240, 1, 1, 1, BG, 1);

    wr(0, 100, 50, 10, 10, 24'hFF0000, 1, 0);
    step(100, 50, 1, 1, 1, BG, 1);
    commit();
    apply(1);

    wr(0, 190, 190, 20, 20, 24'h0000FF, 1, 0);
    wr(1, 195, 195, 20, 20, 24'h00FF00, 1, 0);
    commit();
    apply(2);
    wr(0, 190, 190, 20, 20, 24'h0000FF, 0, 0);
    commit();
    apply(3);

    wr(2, 300, 300, 5, 5, 24'hABCDEF, 1, 1);
    apply(4);
    commit();
    apply(5);
    wr(4, 300, 300, 5, 5, 24'h112233, 1, 0);
    commit();
    apply(6);

    wr(3, 635, 100, 20, 10, 24'h00AA00, 1, 0);
    commit();
    apply(7);

`ifdef SPRITE_COLLISION_EN
    wr(0, 400, 400, 10, 10, 24'h0000FF, 1, 0);
    wr(3, 405, 405, 10, 10, 24'h00AA00, 1, 0);
    commit();
    step(407, 407, 1, 1, 1, 24'h0000FF, 1);
    wr(3, 500, 500, 10, 10, 24'h00AA00, 1, 0);
    chk("coll_pre", 32'(coll), 0);
    commit();
    chk("coll_set", 32'(coll), 32'b1001);
    step(407, 407, 1, 1, 1, 24'h0000FF, 1);
    commit();
    chk("coll_clr", 32'(coll), 0);
`else
    wr(0, 400, 400, 10, 10, 24'h0000FF, 1, 0);
    wr(3, 405, 405, 10, 10, 24'h00AA00, 1, 0);
    commit();
    step(407, 407, 1, 1, 1, 24'h0000FF, 1);
    commit();
    chk("coll_off", 32'(coll), 0);
`endif

    wr(0, 310, 230, 20, 20, 24'h0000FF, 1, 0);
    commit();
    step(320, 240, 1, 1, 1, 24'h0000FF, 1);
    step(320, 240, 1, 0, 1, 24'h0000FF, 1);
    rst = 1;
    #1;
    chk("midrst_rgb", 32'({r, g, b}), 0);
    chk("midrst_sync", 32'({hs_o, bl_o}), 32'b10);
    q.delete();
    @(negedge clk);
    rst = 0;
    commit();
    apply(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_pixel_pipe.md
SPRITE_PIXEL_PIPE -- requirements
Module: sprite_pixel_pipe

Interface
REQ-001 SHALL have parameter NUM_SPR, default 4, giving the number of sprite slots (1..8).
REQ-002 SHALL have parameter BG_COLOR, default 24'h000000, giving the RGB used where no sprite hits.
REQ-003 SHALL have port VGA_clk, input, 1 bit: pixel clock, the only clock in the block.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have ports xCount and yCount, input, 10 bits each: pixel coordinates from the VGA controller.
REQ-006 SHALL have ports blank_n, hsync and vsync, input, 1 bit each: timing from the VGA controller.
REQ-007 SHALL have port wr_en, input, 1 bit: write strobe for the sprite shadow registers.
REQ-008 SHALL have port wr_idx, input, 3 bits: slot index; writes to idx >= NUM_SPR are ignored.
REQ-009 SHALL have ports wr_x and wr_y, input, 10 bits each: sprite top-left corner.
REQ-010 SHALL have ports wr_w and wr_h, input, 7 bits each: size in pixels; 0 means the sprite is invisible.
REQ-011 SHALL have ports wr_color, input, 24 bits, and wr_vis, input, 1 bit: sprite colour and enable.
REQ-012 SHALL have ports r_out, g_out and b_out, output, 8 bits each: pixel colour.
REQ-013 SHALL have ports hsync_out, vsync_out and blank_n_out, output, 1 bit each: timing delayed to align with the colour outputs.
REQ-014 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each commit.
REQ-015 SHALL have port coll_flags, output, NUM_SPR bits: per-sprite collision flags (only with SPRITE_COLLISION_EN).

Function
REQ-016 On wr_en with a valid wr_idx, the block SHALL load all fields of that slot into its shadow register on the same clock edge.
REQ-017 A commit SHALL occur on the cycle where xCount==0 and yCount==480; it copies all shadow registers to the active registers and pulses frame_tick high for exactly that cycle.
REQ-018 A write coinciding with a commit SHALL update the shadow register only; the committed value is the pre-write shadow, and the new value takes effect at the next commit.
REQ-019 Stage 1 SHALL register xCount, yCount, blank_n, hsync and vsync.
REQ-020 Stage 2 SHALL compute the hit and colour from stage-1 values and register the RGB and timing outputs; total latency SHALL be exactly 2 cycles for all outputs.
REQ-021 Sprite i SHALL hit when vis=1, x >= sx, x < sx+w, y >= sy and y < sy+h.
REQ-022 The hit sums SHALL be computed at 11 bits with no wrap, so a sprite extending past 639 or 479 is clipped.
REQ-023 When several sprites hit, the lowest index SHALL win; with no hit the output SHALL be BG_COLOR.
REQ-024 When the stage-1 blank_n is 0, the RGB outputs SHALL be 0 regardless of hits.

Reset
REQ-025 While rst is high, the block SHALL clear all shadow and active registers (vis=0) and the pipeline registers.
REQ-026 While rst is high, RGB, frame_tick and coll_flags SHALL be 0, hsync_out and vsync_out SHALL be 1 (inactive), and blank_n_out SHALL be 0.
REQ-027 An rst assertion mid-frame SHALL take effect immediately; after release, output SHALL be BG_COLOR in the visible area until sprites are written and committed.

Configuration
REQ-028 With macro SPRITE_COLLISION_EN defined, a sticky flag per sprite SHALL be set when that sprite and at least one other sprite hit the same visible pixel.
REQ-029 With SPRITE_COLLISION_EN defined, coll_flags SHALL load the sticky flags at each commit, and the sticky flags SHALL clear in that same cycle.
REQ-030 With SPRITE_COLLISION_EN undefined, coll_flags SHALL be tied to 0 and no collision logic SHALL be synthesised.

Verification
REQ-031 Write slot 0 (x=100, y=50, w=10, h=10, red, vis=1), then run to commit: in the next frame, pixel (100,50) is FF0000 two cycles after those coordinates, and pixel (110,50) is BG_COLOR.
REQ-032 Slots 0 (blue) and 1 (green) both cover (200,200) -> output 0000FF; clear vis on slot 0 and commit -> output 00FF00.
REQ-033 Write slot 2 on the exact commit cycle -> no change this frame; change visible after the next frame_tick.
REQ-034 Sprite at x=635, w=20 -> x=635..639 coloured, no wrap to x=0..14; blank region RGB=0; hsync_out equals hsync delayed by exactly 2.
REQ-035 Assert rst at (320,240) -> outputs 0 and hsync_out=1 immediately; after release, no sprites are drawn.
REQ-036 With SPRITE_COLLISION_EN, overlap slots 0 and 3 for one frame -> coll_flags=4'b1001 after the commit; separate the sprites -> 4'b0000 one frame later.
